// File: rtl/secded_pkg.sv
// Shared types and elaboration-time helpers for the SECDED stream decoder.
package secded_pkg;

   typedef enum logic [1:0] {
      ERR_NONE   = 2'd0,
      ERR_CORR   = 2'd1,
      ERR_UNCORR = 2'd2
   } err_type_e;

   // Smallest r with 2^r >= data_w + r + 1.
   function automatic int par_w(input int data_w);
      int r;
      r = 1;
      while ((1 << r) < data_w + r + 1) r++;
      return r;
   endfunction

   function automatic logic is_pow2(input int idx);
      return (idx > 0) && ((idx & (idx - 1)) == 0);
   endfunction

endpackage

// File: rtl/secded_syndrome.sv
// Combinational Hamming syndrome and overall parity of one received code word.
module secded_syndrome
   import secded_pkg::*;
#(
   parameter  int DATA_W = 4,
   localparam int PAR_W  = par_w(DATA_W),
   localparam int CW     = DATA_W + PAR_W + 1
) (
   input  logic [CW-1:0]    code_in,
   output logic [PAR_W-1:0] s,
   output logic             p
);

   // Bit 0 is the overall parity bit and never contributes to the syndrome.
   always_comb begin
      s = '0;
      p = ^code_in;
      for (int i = 1; i < CW; i++) begin
         if (code_in[i]) s = s ^ PAR_W'(i);
      end
   end

endmodule

// File: rtl/secded_stream_dec.sv
// Two-stage valid/ready SECDED decoder with saturating corrected/uncorrectable counters.
module secded_stream_dec
   import secded_pkg::*;
#(
   parameter  int DATA_W = 4,
   parameter  int CNT_W  = 16,
   localparam int PAR_W  = par_w(DATA_W),
   localparam int CW     = DATA_W + PAR_W + 1,
   localparam int POS_W  = $clog2(CW)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CW-1:0]     code_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] data_out,
   output logic [1:0]        err_type,
   output logic [POS_W-1:0]  err_pos,
   input  logic              clr_cnt,
   output logic [CNT_W-1:0]  corr_cnt,
   output logic [CNT_W-1:0]  uncorr_cnt
);

   logic [PAR_W-1:0]  syn_p0;
   logic              par_p0;

   logic              vld_p1_q;
   logic [CW-1:0]     code_p1_q;
   logic [PAR_W-1:0]  syn_p1_q;
   logic              par_p1_q;

   logic [CW-1:0]     fix_p1;
   logic [DATA_W-1:0] data_p2_d, data_p2_q;
   err_type_e         err_p2_d, err_p2_q;
   logic [POS_W-1:0]  pos_p2_d, pos_p2_q;
   logic              vld_p2_q;

   logic [CNT_W-1:0]  corr_q, uncorr_q;
   logic              s1_adv, s2_adv;

   // Payload bits sit at the non-power-of-two positions, lowest index first.
   function automatic logic [DATA_W-1:0] extract(input logic [CW-1:0] code);
      logic [DATA_W-1:0] d;
      int k;
      d = '0;
      k = 0;
      for (int i = 1; i < CW; i++) begin
         if (!is_pow2(i)) begin
            d[k] = code[i];
            k++;
         end
      end
      return d;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + CNT_W'(1);
   endfunction

   assign s2_adv   = !vld_p2_q || out_ready;
   assign s1_adv   = vld_p1_q && s2_adv;
   assign in_ready = !vld_p1_q || s1_adv;

   // ---- stage 0 -> 1: syndrome and parity of the incoming word
   secded_syndrome #(.DATA_W(DATA_W)) u_syn (
      .code_in (code_in),
      .s       (syn_p0),
      .p       (par_p0)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1_q <= 1'b0;
      end else if (in_ready) begin
         vld_p1_q <= in_valid;
      end
      if (in_ready && in_valid) begin
         code_p1_q <= code_in;
         syn_p1_q  <= syn_p0;
         par_p1_q  <= par_p0;
      end
   end

   // ---- stage 1 -> 2: classify and correct
   always_comb begin
      fix_p1   = code_p1_q;
      err_p2_d = ERR_NONE;
      pos_p2_d = '0;
      if (par_p1_q) begin
         if (int'(syn_p1_q) < CW) begin
            err_p2_d         = ERR_CORR;
            pos_p2_d         = POS_W'(syn_p1_q);
            fix_p1[syn_p1_q] = !code_p1_q[syn_p1_q];
         end else begin
            err_p2_d = ERR_UNCORR;
         end
      end else if (syn_p1_q != '0) begin
         err_p2_d = ERR_UNCORR;
      end
      data_p2_d = extract(fix_p1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p2_q  <= 1'b0;
         data_p2_q <= '0;
         err_p2_q  <= ERR_NONE;
         pos_p2_q  <= '0;
      end else if (s2_adv) begin
         vld_p2_q <= vld_p1_q;
         if (vld_p1_q) begin
            data_p2_q <= data_p2_d;
            err_p2_q  <= err_p2_d;
            pos_p2_q  <= pos_p2_d;
         end
      end
   end

   // ---- output handshake: error counters
   always_ff @(posedge clk) begin
      if (rst || clr_cnt) begin
         corr_q   <= '0;
         uncorr_q <= '0;
      end else if (vld_p2_q && out_ready) begin
         if (err_p2_q == ERR_CORR)   corr_q   <= sat_inc(corr_q);
         if (err_p2_q == ERR_UNCORR) uncorr_q <= sat_inc(uncorr_q);
      end
   end

   assign out_valid  = vld_p2_q;
   assign data_out   = data_p2_q;
   assign err_type   = err_p2_q;
   assign err_pos    = pos_p2_q;
   assign corr_cnt   = corr_q;
   assign uncorr_cnt = uncorr_q;

endmodule

// File: tb/tb_secded_stream_dec.sv
// Scoreboard bench for secded_stream_dec at DATA_W=4 (CW=8) with 2-bit counters.
module tb_secded_stream_dec;

   localparam int DATA_W = 4;
   localparam int CNT_W  = 2;

   logic       clk = 1'b0;
   logic       rst, in_valid, out_ready, clr_cnt;
   logic [7:0] code_in;
   logic       in_ready, out_valid;
   logic [3:0] data_out;
   logic [1:0] err_type;
   logic [2:0] err_pos;
   logic [1:0] corr_cnt, uncorr_cnt;

   typedef struct packed {
      logic [3:0] data;
      logic [1:0] err;
      logic [2:0] pos;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e, hold_v;
   logic hold_f = 1'b0;
   logic done;
   int   n_chk = 0;
   int   n_err = 0;

   secded_stream_dec #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .code_in    (code_in),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .data_out   (data_out),
      .err_type   (err_type),
      .err_pos    (err_pos),
      .clr_cnt    (clr_cnt),
      .corr_cnt   (corr_cnt),
      .uncorr_cnt (uncorr_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Independent encoder: data at positions 3,5,6,7; checks at 1,2,4; overall parity at 0.
   function automatic logic [7:0] enc(input logic [3:0] d);
      logic [7:0] c;
      c    = '0;
      c[3] = d[0];
      c[5] = d[1];
      c[6] = d[2];
      c[7] = d[3];
      c[1] = c[3] ^ c[5] ^ c[7];
      c[2] = c[3] ^ c[6] ^ c[7];
      c[4] = c[5] ^ c[6] ^ c[7];
      c[0] = ^c[7:1];
      return c;
   endfunction

   task automatic mk(input logic [3:0] d, input int nf, input int a, input int b,
                     output logic [7:0] c, output exp_t e);
      logic [7:0] m;
      m = '0;
      if (nf >= 1) m[a] = 1'b1;
      if (nf == 2) m[b] = 1'b1;
      c = enc(d) ^ m;
      e.data = (nf == 2) ? {c[7], c[6], c[5], c[3]} : d;
      e.err  = (nf == 0) ? 2'd0 : (nf == 1) ? 2'd1 : 2'd2;
      e.pos  = (nf == 1) ? a[2:0] : 3'd0;
   endtask

   task automatic send(input logic [7:0] c, input exp_t e);
      int t;
      t = 0;
      @(negedge clk);
      in_valid = 1'b1;
      code_in  = c;
      #1;
      while (!in_ready && t < 200) begin
         @(negedge clk);
         #1;
         t++;
      end
      if (!in_ready) begin
         chk("send_timeout", 32'(in_ready), 32'd1);
         in_valid = 1'b0;
         return;
      end
      sb_q.push_back(e);
      @(posedge clk);
   endtask

   task automatic send_w(input logic [3:0] d, input int nf, input int a, input int b);
      logic [7:0] c;
      exp_t e;
      mk(d, nf, a, b, c, e);
      send(c, e);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while (sb_q.size() != 0 && t < 500) begin
         @(negedge clk);
         in_valid = 1'b0;
         t++;
      end
      chk("drain", 32'(sb_q.size()), 32'd0);
   endtask

   // Output monitor: pops on every handshake and checks outputs hold while stalled.
   always @(negedge clk) begin
      #1;
      if (rst) begin
         hold_f = 1'b0;
      end else begin
         if (hold_f)
            chk("stall_hold", 32'({out_valid, data_out, err_type, err_pos}), 32'({1'b1, hold_v}));
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               chk("sb_underflow", 32'd0, 32'd1);
            end else begin
               mon_e = sb_q.pop_front();
               chk("data_out", 32'(data_out), 32'(mon_e.data));
               chk("err_type", 32'(err_type), 32'(mon_e.err));
               chk("err_pos",  32'(err_pos),  32'(mon_e.pos));
            end
         end
         hold_f = out_valid && !out_ready;
         hold_v = {data_out, err_type, err_pos};
      end
   end

   initial begin
      #400000;
      $display("FAIL global_timeout");
      $fatal(1, "bench timeout");
   end

   initial begin
      logic [7:0] c;
      exp_t e;
      int a;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clr_cnt = 1'b0; code_in = '0;
      done = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_data",      32'(data_out), 32'd0);
      chk("rst_err_type",  32'(err_type), 32'd0);
      chk("rst_err_pos",   32'(err_pos), 32'd0);
      chk("rst_corr",      32'(corr_cnt), 32'd0);
      chk("rst_uncorr",    32'(uncorr_cnt), 32'd0);
      chk("rst_in_ready",  32'(in_ready), 32'd1);

      // Clean word latency: handshake at one edge, out_valid after the second.
      @(negedge clk);
      in_valid = 1'b1;
      code_in  = 8'hAA;
      mk(4'hB, 0, 0, 0, c, e);
      sb_q.push_back(e);
      @(negedge clk);
      in_valid = 1'b0;
      #1 chk("lat_1cyc", 32'(out_valid), 32'd0);
      @(negedge clk);
      #1 chk("lat_2cyc", 32'(out_valid), 32'd1);
      idle(3);

      send_w(4'hB, 1, 5, 0);
      idle(4);
      chk("corr_after_8A", 32'(corr_cnt), 32'd1);
      send_w(4'hB, 1, 0, 0);
      idle(4);
      chk("corr_after_AB", 32'(corr_cnt), 32'd2);
      send_w(4'hB, 2, 5, 6);
      idle(4);
      chk("uncorr_after_CA", 32'(uncorr_cnt), 32'd1);
      chk("corr_after_CA",   32'(corr_cnt), 32'd2);

      // Backpressure: three words against a stalled sink.
      @(negedge clk);
      out_ready = 1'b0;
      fork
         begin
            send_w(4'hB, 0, 0, 0);
            send_w(4'hB, 1, 5, 0);
            send_w(4'hB, 2, 5, 6);
         end
         begin
            repeat (6) @(negedge clk);
            chk("bp_in_ready_low", 32'(in_ready), 32'd0);
            chk("bp_sb_depth",     32'(sb_q.size()), 32'd2);
            out_ready = 1'b1;
         end
      join
      wait_drain();
      chk("bp_corr",   32'(corr_cnt), 32'd3);
      chk("bp_uncorr", 32'(uncorr_cnt), 32'd2);

      // Clear, then saturation at 3.
      @(negedge clk);
      clr_cnt = 1'b1;
      @(negedge clk);
      clr_cnt = 1'b0;
      #1;
      chk("clr_corr",   32'(corr_cnt), 32'd0);
      chk("clr_uncorr", 32'(uncorr_cnt), 32'd0);
      for (int i = 0; i < 4; i++)
         send_w(4'($urandom_range(0, 15)), 1, $urandom_range(0, 7), 0);
      wait_drain();
      idle(2);
      chk("corr_saturated", 32'(corr_cnt), 32'd3);

      // clr_cnt coincident with a corrected handshake.
      @(negedge clk);
      out_ready = 1'b0;
      send_w(4'h6, 1, 3, 0);
      a = 0;
      while (!out_valid && a < 20) begin
         @(negedge clk);
         in_valid = 1'b0;
         #1;
         a++;
      end
      chk("clr_hs_valid", 32'(out_valid), 32'd1);
      @(negedge clk);
      clr_cnt   = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      clr_cnt = 1'b0;
      #1;
      chk("clr_hs_corr", 32'(corr_cnt), 32'd0);
      idle(2);
      chk("clr_hs_corr_later", 32'(corr_cnt), 32'd0);
      chk("clr_hs_sb", 32'(sb_q.size()), 32'd0);

      // Reset with two words in flight.
      @(negedge clk);
      out_ready = 1'b0;
      send_w(4'h3, 1, 6, 0);
      send_w(4'h9, 2, 1, 2);
      @(negedge clk);
      in_valid = 1'b0;
      rst      = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      sb_q.delete();
      #1;
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_in_ready",  32'(in_ready), 32'd1);
      out_ready = 1'b1;
      idle(5);
      chk("mid_rst_out_valid_later", 32'(out_valid), 32'd0);
      chk("mid_rst_corr",   32'(corr_cnt), 32'd0);
      chk("mid_rst_uncorr", 32'(uncorr_cnt), 32'd0);

      // Random stream with random sink backpressure.
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               a = $urandom_range(0, 7);
               send_w(4'($urandom_range(0, 15)), $urandom_range(0, 2), a,
                      (a + $urandom_range(1, 7)) % 8);
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(negedge clk);
               out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      @(negedge clk);
      out_ready = 1'b1;
      wait_drain();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/secded_stream_dec.md
SECDED_STREAM_DEC -- requirements
Module: secded_stream_dec

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter DATA_W, default 4, meaning payload width; legal values are 4..64.
REQ-003 Parameter CNT_W, default 16, meaning width of each error counter.
REQ-004 Derived PAR_W SHALL be the smallest r with 2^r >= DATA_W+r+1, and CW SHALL equal DATA_W+PAR_W+1.
REQ-005 Ports (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  code word present
- in_ready  out  1  block accepts code word
- code_in  in  CW  received code word
- out_valid  out  1  result present
- out_ready  in  1  sink accepts result
- data_out  out  DATA_W  corrected payload
- err_type  out  2  result class: 0 = none, 1 = corrected, 2 = uncorrectable
- err_pos  out  $clog2(CW)  flipped bit index; 0 unless err_type = 1
- clr_cnt  in  1  synchronous clear of both counters
- corr_cnt  out  CNT_W  saturating count of corrected words
- uncorr_cnt  out  CNT_W  saturating count of uncorrectable words

Function
REQ-006 Bit 0 of code_in SHALL be the overall parity bit, so the XOR of all CW bits equals 0 for a clean word.
REQ-007 Bits 1..CW-1 SHALL be Hamming positions, with check bits at the power-of-two indices.
REQ-008 Payload bits SHALL occupy the remaining indices in ascending order, with data bit 0 at the lowest such index.
REQ-009 Syndrome s SHALL be the XOR of all indices i in 1..CW-1 with code_in[i]=1; p SHALL be the XOR of all CW bits.
REQ-010 Classification SHALL be:
- s=0, p=0: none.
- p=1 and s<CW: corrected; invert bit s, with s=0 meaning the parity bit itself; err_pos=s.
- s!=0, p=0: uncorrectable.
- p=1 and s>=CW: uncorrectable.
REQ-011 On an uncorrectable word, data_out SHALL carry the uncorrected payload bits.
REQ-012 The datapath SHALL be a 2-stage pipeline. Stage 1 registers the code word, s and p; stage 2 registers the corrected data, err_type and err_pos.
REQ-013 Latency SHALL be 2 cycles from the in_valid&in_ready handshake to out_valid with no backpressure, and throughput SHALL be 1 word per cycle.
REQ-014 Each stage SHALL load when it is empty or the downstream stage advances; in_ready SHALL equal !s1_valid || s1_advance.
REQ-015 While out_valid=1 and out_ready=0, data_out, err_type and err_pos SHALL remain stable, and no word SHALL be dropped or duplicated.
REQ-016 The counters SHALL increment only on an out_valid&out_ready handshake, according to err_type.
REQ-017 The counters SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-018 clr_cnt SHALL take priority: a handshake in the same cycle as clr_cnt SHALL NOT be counted, and both counters read 0 the next cycle.

Reset
REQ-019 After rst, out_valid, all stage valids, data_out, err_type, err_pos, corr_cnt and uncorr_cnt SHALL be 0.
REQ-020 in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-021 rst asserted mid-stream SHALL discard in-flight words, and those words SHALL NOT update the counters.

Structure
REQ-022 Package secded_pkg SHALL hold:
- enum err_type_e (ERR_NONE, ERR_CORR, ERR_UNCORR);
- function par_w(data_w);
- function is_pow2(idx).
REQ-023 Combinational sub-module secded_syndrome (parameter DATA_W; outputs s and p) SHALL be instantiated in stage 1.

Verification (DATA_W=4, CW=8; data 4'hB encodes to 8'hAA)
REQ-024 Clean word: code_in=8'hAA -> data_out=4'hB, err_type=0, err_pos=0, out_valid exactly 2 cycles later.
REQ-025 Single data-bit error: code_in=8'h8A (bit 5 flipped) -> data_out=4'hB, err_type=1, err_pos=5, corr_cnt=1.
REQ-026 Parity-bit error and double error:
- code_in=8'hAB -> data_out=4'hB, err_type=1, err_pos=0.
- code_in=8'hCA (bits 5 and 6 flipped) -> err_type=2, uncorr_cnt=1.
REQ-027 Backpressure: stream 8'hAA, 8'h8A, 8'hCA with out_ready held 0 for 5 cycles, then 1 -> in_ready drops after 2 words are accepted; the outputs appear in order, each exactly once, held stable while stalled.
REQ-028 Counters and reset:
- With CNT_W=2: 4 corrected words -> corr_cnt=3 (saturated).
- clr_cnt in the same cycle as a corrected handshake -> corr_cnt=0.
- rst with 2 words in flight -> out_valid=0 and the counters stay 0.
